// File: rtl/vga_line_fetch_pkg.sv
// Shared geometry, pixel width and fill-FSM state encodings for the VGA line fetcher.
package vga_line_fetch_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int V_TOTAL    = 525;
  localparam int PIXEL_SIZE = 8;
  localparam int CNT_W      = 11;
  localparam int X_W        = $clog2(H_ACTIVE);

  typedef enum logic [1:0] {
    LF_IDLE    = 2'd0,
    LF_FETCH   = 2'd1,
    LF_RESTART = 2'd2
  } lf_state_t;

  // Line to be fetched after a swap: the one after vcount, wrapping at frame end.
  function automatic logic [CNT_W-1:0] next_line(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Two-bank line buffer: one synchronous write port (fill), one synchronous read port (display).
module vga_line_ram
  import vga_line_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic                  wbank,
  input  logic [X_W-1:0]        wx,
  input  logic [PIXEL_SIZE-1:0] wdata,
  input  logic                  re,
  input  logic                  rbank,
  input  logic [X_W-1:0]        rx,
  output logic [PIXEL_SIZE-1:0] rdata
);

  logic [PIXEL_SIZE-1:0] mem [2][H_ACTIVE];

  always_ff @(posedge clk) begin
    if (we) mem[wbank][wx] <= wdata;
    if (re) rdata <= mem[rbank][rx];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Double-buffered line fetcher between the VGA timing generator and the DAC.
// Optional macro VGA_LF_UNDERRUN_EN adds a sticky underrun flag and paints aborted lines white.
module vga_line_fetch
  import vga_line_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pix_ce,
  input  logic [CNT_W-1:0]      hcount,
  input  logic [CNT_W-1:0]      vcount,
  input  logic                  blank,
  output logic [PIXEL_SIZE-1:0] pixel,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [PIXEL_SIZE-1:0] mem_rdata,
`ifdef VGA_LF_UNDERRUN_EN
  output logic                  underrun,
`endif
  output logic [1:0]            dbg_state,
  output logic                  dbg_disp_bank
);

  // Memory handshake: mem_req is high exactly in LF_FETCH; mem_addr only moves on an ack
  // or on a swap, so the address is stable for as long as a request is outstanding.
  lf_state_t             state_q, state_d;
  logic                  disp_bank;
  logic [X_W-1:0]        fill_x;
  logic [CNT_W-1:0]      line_l;
  logic                  sw, start_fill, ack_ok, last_ack, visible;
  logic [ADDR_W-1:0]     start_addr;
  logic                  vis_q;
  logic [PIXEL_SIZE-1:0] ram_rdata;

  always_comb begin
    sw         = pix_ce && (hcount == CNT_W'(H_ACTIVE));
    line_l     = next_line(vcount);
    start_fill = sw && (line_l < CNT_W'(V_ACTIVE));
    ack_ok     = (state_q == LF_FETCH) && mem_ack;
    last_ack   = ack_ok && (fill_x == X_W'(H_ACTIVE - 1));
    visible    = !blank && (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
    start_addr = BASE_ADDR + ADDR_W'(line_l) * ADDR_W'(H_ACTIVE);
    state_d    = state_q;
    case (state_q)
      LF_IDLE: if (start_fill) state_d = LF_FETCH;
      LF_FETCH, LF_RESTART: begin
        // A swap mid-fill aborts; LF_RESTART is the one idle cycle before the new fill.
        if (sw)                         state_d = start_fill ? LF_RESTART : LF_IDLE;
        else if (state_q == LF_RESTART) state_d = LF_FETCH;
        else if (last_ack)              state_d = LF_IDLE;
      end
      default: state_d = LF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= LF_IDLE;
      disp_bank <= 1'b0;
      fill_x    <= '0;
      mem_addr  <= '0;
      vis_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (sw) begin
        disp_bank <= ~disp_bank;
        fill_x    <= '0;
        if (start_fill) mem_addr <= start_addr;
      end else if (ack_ok) begin
        fill_x   <= fill_x + 1'b1;
        mem_addr <= mem_addr + 1'b1;
      end
      if (pix_ce) vis_q <= visible;
    end
  end

  assign mem_req       = (state_q == LF_FETCH);
  assign dbg_state     = state_q;
  assign dbg_disp_bank = disp_bank;

  // An ack coinciding with a swap still lands in the pre-swap fill bank.
  vga_line_ram u_ram (
    .clk   (clk),
    .we    (ack_ok),
    .wbank (~disp_bank),
    .wx    (fill_x),
    .wdata (mem_rdata),
    .re    (pix_ce && visible),
    .rbank (disp_bank),
    .rx    (hcount[X_W-1:0]),
    .rdata (ram_rdata)
  );

`ifdef VGA_LF_UNDERRUN_EN
  logic disp_bad, ovr_q, underrun_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      disp_bad   <= 1'b0;
      ovr_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (sw) begin
        disp_bad <= (state_q != LF_IDLE);
        if (state_q != LF_IDLE) underrun_q <= 1'b1;
      end
      if (pix_ce) ovr_q <= visible && disp_bad;
    end
  end

  assign underrun = underrun_q;
  assign pixel    = ovr_q ? '1 : (vis_q ? ram_rdata : '0);
`else
  // The RAM read register is the pixel register; vis_q zeroes it outside the active area.
  assign pixel = vis_q ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized bench for vga_line_fetch against a line-level model of banks, fills and display.
module tb_vga_line_fetch;
  import vga_line_fetch_pkg::*;

  localparam logic [22:0] BASE = 23'h100;

  logic        clk = 1'b0;
  logic        resetn, pix_ce, blank, mem_ack, mem_req, dbg_disp_bank;
  logic [10:0] hcount, vcount;
  logic [7:0]  pixel, mem_rdata;
  logic [22:0] mem_addr;
  logic [1:0]  dbg_state;
`ifdef VGA_LF_UNDERRUN_EN
  logic        underrun;
`endif

  int total = 0;
  int bad   = 0;

  // Clock / reset
  always #5 clk = ~clk;

  vga_line_fetch #(.ADDR_W(23), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount),
    .blank(blank), .pixel(pixel), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef VGA_LF_UNDERRUN_EN
    .underrun(underrun),
`endif
    .dbg_state(dbg_state), .dbg_disp_bank(dbg_disp_bank)
  );

  function automatic logic [7:0] mem_fn(input logic [22:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ a[22:15];
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  // Reference model: bank contents as seen by the display, plus fill progress
  logic [7:0] m_bank [2][640];
  bit         m_known [2][640];
  bit         m_disp, m_active, m_wait, m_bad, m_under, m_pix_known;
  int         m_line, m_k;
  logic [7:0] m_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_active = 0; m_wait = 0; m_bad = 0; m_under = 0;
    m_line = 0; m_k = 0; m_pix = 8'h00; m_pix_known = 1;
    for (int b = 0; b < 2; b++)
      for (int x = 0; x < 640; x++) m_known[b][x] = 0;
  endtask

  // One clock: capture pre-edge inputs, advance the model, then check outputs after the edge.
  task automatic tick();
    bit rst_p, sw_p, ack_p, vis_p, busy_p, ce_p;
    int l_p, h_p;
    rst_p  = resetn;
    ce_p   = pix_ce;
    h_p    = int'(hcount);
    sw_p   = pix_ce && (hcount == 11'd640);
    l_p    = (vcount == 11'd524) ? 0 : int'(vcount) + 1;
    ack_p  = mem_ack && m_active;
    busy_p = m_active || m_wait;
    vis_p  = !blank && (hcount < 11'd640) && (vcount < 11'd480);
    @(posedge clk);
    #1;
    if (!rst_p) begin
      model_reset();
    end else begin
      if (ce_p) begin
        if (!vis_p) begin
          m_pix = 8'h00; m_pix_known = 1;
`ifdef VGA_LF_UNDERRUN_EN
        end else if (m_bad) begin
          m_pix = 8'hff; m_pix_known = 1;
`endif
        end else begin
          m_pix = m_bank[m_disp][h_p]; m_pix_known = m_known[m_disp][h_p];
        end
      end
      if (ack_p) begin
        m_bank[m_disp ^ 1'b1][m_k]  = mem_fn(23'(BASE + m_line * 640 + m_k));
        m_known[m_disp ^ 1'b1][m_k] = 1;
        m_k++;
        if (m_k == 640) m_active = 0;
      end
      if (m_wait && !sw_p) begin
        m_active = 1; m_wait = 0;
      end
      if (sw_p) begin
        m_disp = m_disp ^ 1'b1;
        m_bad  = busy_p;
        if (busy_p) m_under = 1;
        m_k = 0;
        if (l_p < 480) begin
          m_line = l_p; m_active = !busy_p; m_wait = busy_p;
        end else begin
          m_active = 0; m_wait = 0;
        end
      end
    end
    check("mem_req", 32'(mem_req), 32'(m_active));
    if (m_active) check("mem_addr", 32'(mem_addr), 32'(23'(BASE + m_line * 640 + m_k)));
    if (!m_active && !m_wait) check("state_idle", 32'(dbg_state), 32'(LF_IDLE));
    check("disp_bank", 32'(dbg_disp_bank), 32'(m_disp));
    if (m_pix_known) check("pixel", 32'(pixel), 32'(m_pix));
`ifdef VGA_LF_UNDERRUN_EN
    check("underrun", 32'(underrun), 32'(m_under));
`endif
  endtask

  // Driver: one scan line of 700 pixel periods with random gaps between pix_ce strobes.
  task automatic run_line(input int y, input int ack_pct);
    for (int h = 0; h < 700; h++) begin
      hcount  = 11'(h);
      vcount  = 11'(y);
      blank   = (h >= 640) || (y >= 480) || ($urandom_range(0, 49) == 0);
      pix_ce  = 1'b1;
      mem_ack = ($urandom_range(0, 99) < ack_pct);
      tick();
      pix_ce = 1'b0;
      repeat ($urandom_range(0, 1)) begin
        hcount  = 11'($urandom_range(0, 1023));
        vcount  = 11'($urandom_range(0, 600));
        blank   = 1'($urandom_range(0, 1));
        mem_ack = ($urandom_range(0, 99) < ack_pct);
        tick();
      end
    end
  endtask

  initial begin
    resetn = 1'b0; pix_ce = 1'b0; hcount = '0; vcount = '0; blank = 1'b1; mem_ack = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_pixel", 32'(pixel), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(LF_IDLE));
    resetn = 1'b1;
    tick();

    run_line(524, 100);
    run_line(0, 85);
    run_line(1, 85);
    run_line(2, 0);
    run_line(3, 90);
    run_line(4, 90);
    run_line(5, 60);
    run_line(478, 90);
    run_line(479, 90);
    run_line(500, 100);

    // Reset arriving together with an ack while a fill is outstanding
    hcount = 11'd640; vcount = 11'd10; pix_ce = 1'b1; blank = 1'b1; mem_ack = 1'b0;
    tick();
    pix_ce = 1'b0;
    repeat (3) tick();
    check("pre_rst_req", 32'(mem_req), 32'h1);
    check("pre_rst_addr", 32'(mem_addr), 32'(23'(BASE + 11 * 640)));
    resetn = 1'b0; mem_ack = 1'b1;
    tick();
    check("midrst_req", 32'(mem_req), 32'h0);
    check("midrst_addr", 32'(mem_addr), 32'h0);
    check("midrst_pixel", 32'(pixel), 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(LF_IDLE));
    resetn = 1'b1; mem_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
